// File: rtl/cell_stim_sweeper.sv
// Purpose : exhaustively sweeps a 1..4-input logic cell and checks its Y output against a truth table.
// Latency : DONE pulses 2^N_IN*(SETTLE+1) cycles after the START-accept edge.
// Backpres: none; START is only looked at in IDLE, and Y is sampled once per vector.
//
// Ports:
//   CLK      in   sole clock, rising edge
//   RN       in   synchronous active-low reset
//   START    in   sweep request (IDLE only)
//   Y        in   cell-under-test output, already synchronous to CLK
//   VEC      out  cell inputs A=VEC[0], B=VEC[1], C=VEC[2], D=VEC[3]
//   BUSY     out  high while driving or sampling a vector
//   DONE     out  one-cycle pulse at sweep end
//   ERRCNT   out  mismatch count, 0..16
//   FAIL     out  ERRCNT nonzero
//   FIRSTBAD out  VEC value of the first mismatch, 0 when none
//
// Build option: define SWEEP_GRAY_EN to sweep in reflected Gray order instead of binary.

module cell_stim_sweeper #(
    parameter int          N_IN   = 4,
    parameter int          SETTLE = 2,
    parameter logic [15:0] TT     = 16'h0777
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       START,
    input  logic       Y,
    output logic [3:0] VEC,
    output logic       BUSY,
    output logic       DONE,
    output logic [4:0] ERRCNT,
    output logic       FAIL,
    output logic [3:0] FIRSTBAD
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX    = 4'((1 << N_IN) - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_idx;       // sequence position, always binary
    logic [3:0] r_cnt;       // settle counter within DRIVE
    logic [4:0] r_errcnt;
    logic [3:0] r_firstbad;

    logic [3:0] w_vec;
    logic       w_last;
    logic       w_busy;
    logic       w_done;
    logic       w_accept;
    logic       w_mismatch;

    // The index never exceeds 2^N_IN-1, so both mappings keep bits at or
    // above N_IN at zero without extra masking.
`ifdef SWEEP_GRAY_EN
    assign w_vec = r_idx ^ (r_idx >> 1);
`else
    assign w_vec = r_idx;
`endif

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        w_mismatch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_busy = 1'b1;
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_busy      = 1'b1;
                // TT is indexed by the value actually on the pins, so Gray
                // order needs no table remapping.
                w_mismatch  = (Y != TT[w_vec]);
                w_state_nxt = w_last ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_idx      <= 4'd0;
            r_cnt      <= 4'd0;
            r_errcnt   <= 5'd0;
            r_firstbad <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx      <= 4'd0;
                        r_cnt      <= 4'd0;
                        r_errcnt   <= 5'd0;
                        r_firstbad <= 4'd0;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= (r_cnt == SETTLE_LAST) ? 4'd0 : r_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    r_cnt <= 4'd0;
                    if (w_mismatch) begin
                        r_errcnt <= r_errcnt + 5'd1;
                        if (r_errcnt == 5'd0) begin
                            r_firstbad <= w_vec;
                        end
                    end
                    if (!w_last) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_DONE: begin
                    r_idx <= 4'd0;
                end
                default: begin
                    r_idx <= 4'd0;
                end
            endcase
        end
    end

    assign VEC      = w_vec;
    assign BUSY     = w_busy;
    assign DONE     = w_done;
    assign ERRCNT   = r_errcnt;
    assign FAIL     = (r_errcnt != 5'd0);
    assign FIRSTBAD = r_firstbad;

endmodule
